// File: rtl/rotaciona_linhas_fifo.sv
// Row-rotation stage: rotates row r of each ROWS x COLS byte block by r mod COLS bytes, then queues it in a DEPTH-entry FIFO.
// Optional macro ROTACIONA_CONTADOR_EN adds a 16-bit counter of popped blocks on blocos_processados.
module rotaciona_linhas_fifo #(
   parameter int ROWS  = 4,
   parameter int COLS  = 4,
   parameter int DEPTH = 2,
   localparam int W    = 8 * ROWS * COLS,
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          entrada_valid,
   output logic          entrada_ready,
   input  logic [W-1:0]  entrada_bloco,
   input  logic          modo,
   output logic          saida_valid,
   input  logic          saida_ready,
   output logic [W-1:0]  saida_bloco,
   output logic [CW-1:0] ocupacao,
   output logic [15:0]   blocos_processados
);

   localparam int AW = CW - 1;
   localparam logic [CW-1:0] PTR_UM = {{(CW-1){1'b0}}, 1'b1};

   logic [CW-1:0] wr_ptr_r;
   logic [CW-1:0] rd_ptr_r;
   logic [W-1:0]  mem_r [DEPTH];
   logic [W-1:0]  rotacionado_s;
   logic          vazio_s;
   logic          cheio_s;
   logic          push_s;
   logic          pop_s;

   // Byte c of row r takes source byte (c -/+ k) mod COLS; k = r mod COLS, so row 0 is untouched.
   function automatic logic [W-1:0] rotaciona(input logic [W-1:0] bloco, input logic modo_in);
      logic [W-1:0] res;
      int           k;
      int           src;
      res = bloco;
      for (int r = 0; r < ROWS; r++) begin
         k = r % COLS;
         for (int c = 0; c < COLS; c++) begin
            if (modo_in) begin
               src = (c + k) % COLS;
            end else begin
               src = (c - k + COLS) % COLS;
            end
            res[W-1-8*(r*COLS+c) -: 8] = bloco[W-1-8*(r*COLS+src) -: 8];
         end
      end
      return res;
   endfunction

   // Status flags and handshakes, derived only from the registered pointers.
   always_comb begin
      rotacionado_s = rotaciona(entrada_bloco, modo);
      vazio_s       = (wr_ptr_r == rd_ptr_r);
      cheio_s       = (wr_ptr_r[CW-1] != rd_ptr_r[CW-1]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
      push_s        = entrada_valid && !cheio_s;
      pop_s         = saida_ready && !vazio_s;
   end

   // Outputs: head entry is masked to zero while empty so nothing stale shows after reset.
   always_comb begin
      entrada_ready = !cheio_s;
      saida_valid   = !vazio_s;
      ocupacao      = wr_ptr_r - rd_ptr_r;
      if (vazio_s) begin
         saida_bloco = {W{1'b0}};
      end else begin
         saida_bloco = mem_r[rd_ptr_r[AW-1:0]];
      end
   end

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {CW{1'b0}};
         rd_ptr_r <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_UM;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_UM;
         end
      end
   end

   // Storage array; contents are only visible through the empty mask above.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= rotacionado_s;
      end
   end

`ifdef ROTACIONA_CONTADOR_EN
   logic [15:0] contador_r;

   // Pop counter, wraps naturally at 16 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         contador_r <= 16'h0000;
      end else if (pop_s) begin
         contador_r <= contador_r + 16'h0001;
      end else begin
         contador_r <= contador_r;
      end
   end

   assign blocos_processados = contador_r;
`else
   assign blocos_processados = 16'h0000;
`endif

endmodule

// File: tb/tb_rotaciona_linhas_fifo.sv
// Self-checking bench for rotaciona_linhas_fifo: queue-based reference model plus directed block vectors.
module tb_rotaciona_linhas_fifo;

   localparam int D1 = 4;
   localparam logic [127:0] T1_IN  = 128'h50564543415253494c41544641544552;
   localparam logic [127:0] T1_OUT = 128'h505645434941525354464c4154455241;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         v1, m1, sr1, er1, sv1;
   logic [127:0] b1, sb1;
   logic [2:0]   oc1;
   logic [15:0]  bp1;
   logic         v2, m2, sr2, er2, sv2;
   logic [127:0] b2, sb2;
   logic [1:0]   oc2;
   logic [15:0]  bp2;

   int checks = 0;
   int passes = 0;

   logic [127:0] q[$];
   logic [15:0]  cnt1;
   bit           pu1, po1;
   logic [127:0] blk [5];
   logic [127:0] blk_b;

   always #5 clk = ~clk;

   rotaciona_linhas_fifo #(.ROWS(4), .COLS(4), .DEPTH(D1)) dut1 (
      .clk(clk), .rst_n(rst_n), .entrada_valid(v1), .entrada_ready(er1),
      .entrada_bloco(b1), .modo(m1), .saida_valid(sv1), .saida_ready(sr1),
      .saida_bloco(sb1), .ocupacao(oc1), .blocos_processados(bp1));

   rotaciona_linhas_fifo #(.ROWS(2), .COLS(8), .DEPTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .entrada_valid(v2), .entrada_ready(er2),
      .entrada_bloco(b2), .modo(m2), .saida_valid(sv2), .saida_ready(sr2),
      .saida_bloco(sb2), .ocupacao(oc2), .blocos_processados(bp2));

   task automatic chk(input string nome, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %h expected %h", nome, got, exp);
   endtask

   // Whole-row barrel rotation on an 8*cols-bit slice.
   function automatic logic [127:0] modelo(input logic [127:0] b, input logic md, input int rows, input int cols);
      int n, k;
      logic [127:0] one, mask, row, rot, res;
      n = 8 * cols;
      one = 128'h1;
      mask = (one << n) - one;
      res = 128'h0;
      for (int r = 0; r < rows; r++) begin
         row = (b >> (128 - n * (r + 1))) & mask;
         k = 8 * (r % cols);
         if (k == 0) rot = row;
         else if (md) rot = ((row << k) | (row >> (n - k))) & mask;
         else rot = ((row >> k) | (row << (n - k))) & mask;
         res = res | (rot << (128 - n * (r + 1)));
      end
      return res;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         cnt1 <= 16'h0;
      end else begin
         pu1 = v1 && (q.size() != D1);
         po1 = sr1 && (q.size() != 0);
         if (po1) begin
            void'(q.pop_front());
            cnt1 <= cnt1 + 16'h1;
         end
         if (pu1) q.push_back(modelo(b1, m1, 4, 4));
      end
   end

   always @(negedge clk) begin
      chk("ocupacao", {125'h0, oc1}, q.size());
      chk("entrada_ready", {127'h0, er1}, {127'h0, q.size() != D1});
      chk("saida_valid", {127'h0, sv1}, {127'h0, q.size() != 0});
      if (q.size() != 0) chk("saida_bloco", sb1, q[0]);
      if (!rst_n) chk("saida_bloco_reset", sb1, 128'h0);
`ifdef ROTACIONA_CONTADOR_EN
      chk("contador", {112'h0, bp1}, {112'h0, cnt1});
`else
      chk("contador_zero", {112'h0, bp1}, 128'h0);
`endif
   end

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      rst_n = 1'b0;
      v1 = 1'b0; m1 = 1'b0; sr1 = 1'b0; b1 = 128'h0;
      v2 = 1'b0; m2 = 1'b0; sr2 = 1'b0; b2 = 128'h0;
      repeat (3) @(negedge clk);
      chk("rst_ocupacao", {125'h0, oc1}, 128'h0);
      chk("rst_ready", {127'h0, er1}, 128'h1);
      chk("rst_valid", {127'h0, sv1}, 128'h0);
      chk("rst_bloco", sb1, 128'h0);
      rst_n = 1'b1;

      // T1 / T2: known vectors, valid one cycle after push
      @(negedge clk); v1 = 1'b1; m1 = 1'b0; b1 = T1_IN;
      @(negedge clk); v1 = 1'b0;
      chk("t1_valid", {127'h0, sv1}, 128'h1);
      chk("t1_bloco", sb1, T1_OUT);
      sr1 = 1'b1;
      @(negedge clk); sr1 = 1'b0; v1 = 1'b1; m1 = 1'b1; b1 = T1_OUT;
      @(negedge clk); v1 = 1'b0;
      chk("t2_bloco", sb1, T1_IN);
      sr1 = 1'b1;
      @(negedge clk); sr1 = 1'b0;

      // T3: fill to DEPTH with consumer stalled, fifth block waits
      for (int i = 0; i < 5; i++) blk[i] = rnd128();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); v1 = 1'b1; m1 = i[0]; b1 = blk[i];
      end
      chk("t3_full_ocupacao", {125'h0, oc1}, 128'h4);
      chk("t3_full_ready", {127'h0, er1}, 128'h0);
      chk("t3_head", sb1, modelo(blk[0], 1'b0, 4, 4));
      @(negedge clk);
      chk("t3_held", {125'h0, oc1}, 128'h4);
      sr1 = 1'b1;
      @(negedge clk);
      @(negedge clk); v1 = 1'b0;
      repeat (6) @(negedge clk);
      chk("t3_drained", {125'h0, oc1}, 128'h0);
      sr1 = 1'b0;

      // T4: simultaneous push and pop at ocupacao 1
      @(negedge clk); v1 = 1'b1; m1 = 1'b0; b1 = rnd128();
      blk_b = rnd128();
      @(negedge clk); v1 = 1'b1; m1 = 1'b1; b1 = blk_b; sr1 = 1'b1;
      @(negedge clk); v1 = 1'b0; sr1 = 1'b0;
      chk("t4_ocupacao", {125'h0, oc1}, 128'h1);
      chk("t4_head", sb1, modelo(blk_b, 1'b1, 4, 4));
      sr1 = 1'b1;
      @(negedge clk); sr1 = 1'b0;

      // T5: asynchronous reset with blocks held
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); v1 = 1'b1; b1 = rnd128();
      end
      @(negedge clk); v1 = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("t5_ocupacao", {125'h0, oc1}, 128'h0);
      chk("t5_valid", {127'h0, sv1}, 128'h0);
      chk("t5_ready", {127'h0, er1}, 128'h1);
      chk("t5_bloco", sb1, 128'h0);
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("t5_no_stale", {127'h0, sv1}, 128'h0);

      // Randomized traffic against the queue model
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         v1 = ($urandom_range(0, 3) != 0);
         m1 = $urandom_range(0, 1);
         b1 = rnd128();
         sr1 = ($urandom_range(0, 2) != 0) || (i > 2900);
      end
      @(negedge clk); v1 = 1'b0;
      repeat (6) @(negedge clk);
      sr1 = 1'b0;

      // T6: 2x8 geometry and popped-block count
      @(negedge clk); v2 = 1'b1; m2 = 1'b0; b2 = {64'hdeadbeefcafef00d, 64'h0001020304050607};
      @(negedge clk); v2 = 1'b0;
      chk("t6_row1", {64'h0, sb2[63:0]}, {64'h0, 64'h0700010203040506});
      chk("t6_row0", {64'h0, sb2[127:64]}, {64'h0, 64'hdeadbeefcafef00d});
      chk("t6_model", sb2, modelo(b2, 1'b0, 2, 8));
      v2 = 1'b1; m2 = 1'b1; b2 = rnd128(); sr2 = 1'b1;
      @(negedge clk); b2 = rnd128();
      @(negedge clk); v2 = 1'b0;
      @(negedge clk); sr2 = 1'b0;
      chk("t6_empty", {126'h0, oc2}, 128'h0);
`ifdef ROTACIONA_CONTADOR_EN
      chk("t6_contador", {112'h0, bp2}, 128'h3);
`else
      chk("t6_contador_zero", {112'h0, bp2}, 128'h0);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
